serializer_arbiter: RTL and testbench
=====================================

# serializer_arbiter

Round-robin arbiter that shares one byte serializer between two byte producers. Each requester presents a byte with a level request; the arbiter grants one requester at a time, loads its byte into the serializer with a one-cycle start pulse, acknowledges the requester, and waits for the serializer to finish before loading the next byte. A granted requester may send a burst of up to N_BURST back-to-back bytes before the grant is released, and a watchdog flags a serializer that never reports busy.

## Interface
- N_BURST, 4: maximum consecutive bytes per grant (1..15).
- WAIT_TIMEOUT, 255: cycles to wait for ser_busy to rise after ser_start (1..255).

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  client 0 has a byte to send; held until ack0.
- data0  in  8  client 0 byte; stable while req0 is high and ack0 has not been seen.
- ack0  out  1  one-cycle pulse: data0 captured into the serializer.
- req1, data1, ack1: same as client 0.
- grant  out  2  one-hot current owner (01 = client 0, 10 = client 1, 00 = none).
- ser_data  out  8  byte presented to the serializer.
- ser_start  out  1  one-cycle load pulse to the serializer.
- ser_busy  in  1  serializer transmitting.
- err  out  1  sticky watchdog flag.

## Operation
- All outputs are registered. Reset values: grant=00, ser_data=8'h00, ser_start=0, ack0=ack1=0, err=0. Internal state: state=IDLE, last owner=client 1 (client 0 wins first), burst count=0, timeout count=0.
- States:
  - IDLE:
    - No request: stay.
    - Exactly one request: grant that client.
    - Both requesting: grant the client that is not the last owner.
    - On grant, set grant and go to LOAD.
  - LOAD (1 cycle):
    - ser_data <= owner's data; ser_start=1; owner's ack=1.
    - Increment burst count, clear timeout count, go to WAIT_BUSY.
  - WAIT_BUSY:
    - ser_busy=1: go to WAIT_DONE.
    - Otherwise increment timeout count. When it reaches WAIT_TIMEOUT: set err=1, release the grant, go to IDLE. The byte is lost and is not re-acked.
  - WAIT_DONE:
    - Stay while ser_busy=1.
    - On ser_busy=0: if the owner's req=1 and burst count < N_BURST, go to LOAD (same owner, next byte). Otherwise release.
- Release: last owner <= owner, grant <= 00, burst count <= 0, go to IDLE.
- Requester rules:
  - After ack, the requester may present a new byte with req still high in the next cycle. That is a burst continuation.
  - Dropping req before ack is a protocol violation and the behaviour is undefined.
  - A non-owner's req is ignored until it is granted.
- err clears only on reset. The arbiter keeps operating while err=1.
- ser_data holds its last loaded value between loads.
- Reset asserted mid-transfer: all outputs go to their reset values immediately. No ack or start is issued after reset is released until a fresh arbitration.

## Timing
- req sampled high in IDLE at edge k: grant is valid from edge k+1; ser_start, ack and ser_data are updated at edge k+1 and are high for exactly that cycle.
- ser_start and ackX are always coincident, one per byte.
- Burst continuation: ser_busy sampled 0 at edge m gives the next ser_start at edge m+1.
- Release: ser_busy sampled 0 at edge m gives grant=00 at edge m+1 (one IDLE cycle minimum). The next grant appears at edge m+2 at the earliest, even for the other client.
- Watchdog: err is set at edge n+WAIT_TIMEOUT, where n is the edge after ser_start deasserts, if ser_busy stays 0 throughout.

## Test plan
- Single byte: req0=1, data0=8'hA5; serializer model busy 10 cycles after start. Required: grant=01, one ser_start with ser_data=8'hA5, one ack0 in the same cycle, grant=00 one cycle after busy falls.
- Simultaneous first requests: req0 and req1 both rise right after reset, one byte each (8'h11, 8'h22). Required: client 0 is served first (ser_data 8'h11), then grant=10 with ser_data 8'h22; exactly two starts.
- Burst limit and fairness (N_BURST=4): req1 holds bytes 8'h10..8'h15; req0 (8'h99) rises during the first byte. Required order of ser_data: 10, 11, 12, 13, 99, 14, 15. grant goes 10, then 01, then 10.
- Watchdog (WAIT_TIMEOUT=8): ser_busy tied 0, req0 with one byte. Required: ack0 pulses once, err=1 after 8 wait cycles, grant=00. A following req1 byte is still started, and err remains 1.
- Reset mid-burst: assert rst=0 during WAIT_DONE of the second of three bytes. Required: all outputs are at reset values in the same cycle. After release with req1 and req0 both high, client 0 wins, and no stale ack1 appears.

Source files
------------

// File: rtl/serializer_arbiter_if.sv
// ============================================================================
//  Module      : serializer_arbiter_if
//  Description : Bundle of the two requester handshakes, the serializer load
//                port and the status outputs of serializer_arbiter.
//                slave  : arbiter side (takes requests, drives serializer)
//                master : environment side (requesters + serializer)
//  Ports       : req0/data0/ack0, req1/data1/ack1 - requester handshakes
//                grant[1:0]                       - one-hot current owner
//                ser_data[7:0]/ser_start/ser_busy - serializer load port
//                err                              - sticky watchdog flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serializer_arbiter_if;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic [1:0] grant;
    logic [7:0] ser_data;
    logic       ser_start;
    logic       ser_busy;
    logic       err;

    modport slave (
        input  req0, data0, req1, data1, ser_busy,
        output ack0, ack1, grant, ser_data, ser_start, err
    );

    modport master (
        output req0, data0, req1, data1, ser_busy,
        input  ack0, ack1, grant, ser_data, ser_start, err
    );
endinterface

`default_nettype wire

// File: rtl/serializer_arbiter.sv
// ============================================================================
//  Module      : serializer_arbiter
//  Description : Round-robin arbiter sharing one byte serializer between two
//                byte producers. A grant may carry a burst of up to N_BURST
//                bytes; a watchdog flags a serializer that never goes busy.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous, active-low reset
//                bus  - serializer_arbiter_if.slave (requests, serializer,
//                       grant and err)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serializer_arbiter #(
    parameter int N_BURST      = 4,    // 1..15
    parameter int WAIT_TIMEOUT = 255   // 1..255
) (
    input  wire logic           clk,
    input  wire logic           rst,
    serializer_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_BURST_MAX = 4'(N_BURST);
    localparam logic [7:0] c_TMO_LAST  = 8'(WAIT_TIMEOUT - 1);

    state_t     r_state;
    logic       r_owner;        // 0 = client 0, 1 = client 1
    logic       r_last_owner;
    logic [3:0] r_burst_cnt;
    logic [7:0] r_tmo_cnt;
    logic [1:0] r_grant;
    logic [7:0] r_ser_data;
    logic       r_ser_start;
    logic       r_ack0;
    logic       r_ack1;
    logic       r_err;

    logic       w_any_req;
    logic       w_idle_pick;
    logic       w_owner_req;
    logic       w_burst_more;
    logic       w_do_load;
    logic       w_load_sel;

    assign w_any_req    = bus.req0 | bus.req1;
    // Single requester wins outright; on a tie the client that did not own
    // the serializer last time gets it.
    assign w_idle_pick  = (bus.req0 & bus.req1) ? ~r_last_owner : bus.req1;
    assign w_owner_req  = r_owner ? bus.req1 : bus.req0;
    assign w_burst_more = w_owner_req && (r_burst_cnt < c_BURST_MAX);

    // The byte is loaded on the edge that enters LOAD, so ser_start/ack are
    // high exactly during the LOAD cycle.
    assign w_do_load  = ((r_state == S_IDLE) && w_any_req) ||
                        ((r_state == S_WAIT_DONE) && !bus.ser_busy && w_burst_more);
    assign w_load_sel = (r_state == S_IDLE) ? w_idle_pick : r_owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= 4'd0;
            r_tmo_cnt    <= 8'd0;
            r_grant      <= 2'b00;
            r_ser_data   <= 8'h00;
            r_ser_start  <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ser_start <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;

            if (w_do_load) begin
                r_owner     <= w_load_sel;
                r_grant     <= w_load_sel ? 2'b10 : 2'b01;
                r_ser_data  <= w_load_sel ? bus.data1 : bus.data0;
                r_ser_start <= 1'b1;
                r_ack0      <= ~w_load_sel;
                r_ack1      <= w_load_sel;
                r_burst_cnt <= r_burst_cnt + 4'd1;
                r_tmo_cnt   <= 8'd0;
                r_state     <= S_LOAD;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_LOAD: begin
                        r_state <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY: begin
                        if (bus.ser_busy) begin
                            r_state <= S_WAIT_DONE;
                        end else if (r_tmo_cnt == c_TMO_LAST) begin
                            // Byte is dropped: flag it and give up the grant.
                            r_err        <= 1'b1;
                            r_last_owner <= r_owner;
                            r_grant      <= 2'b00;
                            r_burst_cnt  <= 4'd0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        end
                    end
                    S_WAIT_DONE: begin
                        // Reaching here with busy low means no further burst.
                        if (!bus.ser_busy) begin
                            r_last_owner <= r_owner;
                            r_grant      <= 2'b00;
                            r_burst_cnt  <= 4'd0;
                            r_state      <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.ser_data  = r_ser_data;
    assign bus.ser_start = r_ser_start;
    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_serializer_arbiter.sv
// ============================================================================
//  Module      : tb_serializer_arbiter
//  Description : Scoreboard bench for serializer_arbiter. Requester models
//                drive byte queues, a serializer model raises ser_busy after
//                each start, and every observed start is matched against the
//                expected (grant, byte) queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serializer_arbiter;

    localparam int N_BURST      = 4;
    localparam int WAIT_TIMEOUT = 8;
    localparam int BUSY_LEN     = 10;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    serializer_arbiter_if bus ();

    serializer_arbiter #(
        .N_BURST      (N_BURST),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         n_starts = 0;
    int         busy_cnt = 0;
    bit         busy_en  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester models: present the head of the queue, pop it on ack.
    always @(negedge clk) begin
        if (bus.ack0 && q0.size() > 0) void'(q0.pop_front());
        if (bus.ack1 && q1.size() > 0) void'(q1.pop_front());
        bus.req0  = (q0.size() > 0);
        bus.data0 = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.req1  = (q1.size() > 0);
        bus.data1 = (q1.size() > 0) ? q1[0] : 8'h00;
    end

    // Serializer model: busy for BUSY_LEN cycles after each start.
    always @(negedge clk) begin
        if (!rst)
            busy_cnt = 0;
        else if (bus.ser_start && busy_en)
            busy_cnt = BUSY_LEN;
        else if (busy_cnt > 0)
            busy_cnt = busy_cnt - 1;
        bus.ser_busy = (busy_cnt > 0);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.ser_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    chk("extra_start", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ser_data", bus.ser_data, e.data);
                    chk("grant", bus.grant, e.grant);
                    chk("ack_vec", {bus.ack1, bus.ack0}, e.grant);
                end
            end else if (bus.ack0 || bus.ack1) begin
                chk("stray_ack", bus.ser_start, 1);
            end
        end
    end

    task automatic push_exp(input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.grant = g;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input string tag, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.ser_start) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_start_seen"}, ok, 1);
    endtask

    task automatic wait_quiet(input string tag, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
                !bus.ser_busy && bus.grant == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_settle"}, ok, 1);
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        bit ok;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_ser_data", bus.ser_data, 8'h00);
        chk("rst_ser_start", bus.ser_start, 0);
        chk("rst_acks", {bus.ack1, bus.ack0}, 2'b00);
        chk("rst_err", bus.err, 0);
        #2 rst = 1'b1;

        // Simultaneous first requests: client 0 wins, then client 1
        @(posedge clk); #1;
        push_exp(2'b01, 8'h11);
        push_exp(2'b10, 8'h22);
        q0.push_back(8'h11);
        q1.push_back(8'h22);
        wait_quiet("simul", 200);

        // Single byte and release timing
        @(posedge clk); #1;
        push_exp(2'b01, 8'hA5);
        q0.push_back(8'hA5);
        wait_start("single", 50);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (!bus.ser_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("single_busy_fell", ok, 1);
        chk("single_grant_held", bus.grant, 2'b01);
        @(negedge clk); #1;
        chk("single_grant_release", bus.grant, 2'b00);
        wait_quiet("single", 100);

        // Burst limit and fairness
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_exp(2'b10, 8'h10 + 8'(i));
        push_exp(2'b01, 8'h99);
        push_exp(2'b10, 8'h14);
        push_exp(2'b10, 8'h15);
        for (int i = 0; i < 6; i++) q1.push_back(8'h10 + 8'(i));
        wait_start("burst", 50);
        q0.push_back(8'h99);
        wait_quiet("burst", 600);

        // Watchdog: serializer never goes busy
        busy_en = 1'b0;
        @(posedge clk); #1;
        push_exp(2'b01, 8'h5A);
        q0.push_back(8'h5A);
        wait_start("wdog", 50);
        repeat (WAIT_TIMEOUT) @(negedge clk);
        chk("wdog_err_early", bus.err, 0);
        @(negedge clk);
        chk("wdog_err_set", bus.err, 1);
        chk("wdog_grant_release", bus.grant, 2'b00);
        @(posedge clk); #1;
        push_exp(2'b10, 8'h3C);
        q1.push_back(8'h3C);
        wait_quiet("wdog", 100);
        chk("wdog_err_sticky", bus.err, 1);
        busy_en = 1'b1;

        // Reset in the middle of a burst
        @(posedge clk); #1;
        push_exp(2'b10, 8'hA1);
        push_exp(2'b10, 8'hA2);
        base = n_starts;
        q1.push_back(8'hA1);
        q1.push_back(8'hA2);
        q1.push_back(8'hA3);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (n_starts == base + 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mrst_two_starts", ok, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst_grant", bus.grant, 2'b00);
        chk("mrst_ser_data", bus.ser_data, 8'h00);
        chk("mrst_ser_start", bus.ser_start, 0);
        chk("mrst_acks", {bus.ack1, bus.ack0}, 2'b00);
        chk("mrst_err", bus.err, 0);
        chk("mrst_pending", q1.size(), 1);
        q0.push_back(8'h77);
        push_exp(2'b01, 8'h77);
        push_exp(2'b10, 8'hA3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        wait_quiet("mrst", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
